deal_sequencer: RTL and testbench

DEAL_SEQUENCER -- requirements
Module: deal_sequencer

---
 rtl/baccarat_pkg.sv | 16 +
 rtl/dealer_draw_rule.sv | 21 ++
 rtl/deal_sequencer.sv | 100 ++++++++++
 tb/tb_deal_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat deal sequencer.
package baccarat_pkg;

  typedef enum logic [3:0] {
    S_RST, S_P1, S_D1, S_P2, S_D2, S_EVAL_P, S_P3, S_EVAL_D, S_D3, S_SCORE, S_DONE
  } state_e;

  localparam logic [3:0] NATURAL_MIN     = 4'd8;
  localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;

  // Face cards, tens and illegal codes all count as zero.
  function automatic logic [3:0] card_value(input logic [3:0] code);
    return (code >= 4'd1 && code <= 4'd9) ? code : 4'd0;
  endfunction

endpackage

// File: rtl/dealer_draw_rule.sv
// Dealer third-card table: does the banker draw given its two-card score and
// the value of the player's third card.
module dealer_draw_rule (
  input  logic [3:0] dscore,
  input  logic [3:0] v,
  output logic       draw
);

  always_comb begin
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/deal_sequencer.sv
// Baccarat deal sequencer: steps the datapath through card loads, applies the
// third-card rules and latches the result lights.
module deal_sequencer
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
);

  state_e     state_q, state_d;
  logic       pwin_q, pwin_d;
  logic       dwin_q, dwin_d;
  logic [3:0] v;
  logic       dealer_draw;
  logic       natural;

  assign v       = card_value(pcard3);
  assign natural = (pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN);

  dealer_draw_rule u_rule (
    .dscore (dscore),
    .v      (v),
    .draw   (dealer_draw)
  );

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_RST;
      pwin_q  <= 1'b0;
      dwin_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pwin_q  <= pwin_d;
      dwin_q  <= dwin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pwin_d  = pwin_q;
    dwin_d  = dwin_q;
    case (state_q)
      S_RST:    state_d = S_P1;
      S_P1:     state_d = S_D1;
      S_D1:     state_d = S_P2;
      S_P2:     state_d = S_D2;
      S_D2:     state_d = S_EVAL_P;
      S_EVAL_P: begin
        if (natural)                       state_d = S_SCORE;
        else if (pscore <= PLAYER_DRAW_MAX) state_d = S_P3;
        else if (dscore <= PLAYER_DRAW_MAX) state_d = S_D3;
        else                               state_d = S_SCORE;
      end
      S_P3:     state_d = S_EVAL_D;
      S_EVAL_D: state_d = dealer_draw ? S_D3 : S_SCORE;
      S_D3:     state_d = S_SCORE;
      S_SCORE: begin
        state_d = S_DONE;
        pwin_d  = (pscore >= dscore);
        dwin_d  = (dscore >= pscore);
      end
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_RST;
    endcase
  end

  // Loads are a pure decode of the current state.
  always_comb begin
    load_pcard1 = 1'b0;
    load_pcard2 = 1'b0;
    load_pcard3 = 1'b0;
    load_dcard1 = 1'b0;
    load_dcard2 = 1'b0;
    load_dcard3 = 1'b0;
    case (state_q)
      S_P1:    load_pcard1 = 1'b1;
      S_D1:    load_dcard1 = 1'b1;
      S_P2:    load_pcard2 = 1'b1;
      S_D2:    load_dcard2 = 1'b1;
      S_P3:    load_pcard3 = 1'b1;
      S_D3:    load_dcard3 = 1'b1;
      default: ;
    endcase
  end

  assign player_win_light = pwin_q;
  assign dealer_win_light = dwin_q;

endmodule

// File: tb/tb_deal_sequencer.sv
// Self-checking bench for deal_sequencer against a hand-level baccarat model.
module tb_deal_sequencer;

  logic       slow_clock = 1'b0;
  logic       resetb     = 1'b0;
  logic [3:0] pscore = '0, dscore = '0, pcard3 = '0;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light;

  int n_cmp = 0;
  int n_err = 0;

  localparam int NS = 16;
  logic [7:0] obs_tr [NS];
  logic [7:0] exp_tr [NS];

  deal_sequencer dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light)
  );

  always #5 slow_clock = ~slow_clock;

  // {pwin, dwin, d3, d2, d1, p3, p2, p1}
  function automatic logic [7:0] outs();
    return {player_win_light, dealer_win_light, load_dcard3, load_dcard2,
            load_dcard1, load_pcard3, load_pcard2, load_pcard1};
  endfunction

  // Hand-level model: list the loads of the deal in order, then the lights.
  task automatic model_hand(input int ps, input int ds, input int pc,
                            input int psf, input int dsf);
    logic [5:0] seq [$];
    int v, fp, fd;
    bit nat, pdraw, ddraw;
    logic [1:0] lights;
    v     = (pc >= 1 && pc <= 9) ? pc : 0;
    nat   = (ps >= 8) || (ds >= 8);
    pdraw = !nat && ps <= 5;
    if (pdraw)
      ddraw = (ds <= 2) || (ds == 3 && v != 8) ||
              (ds >= 4 && ds <= 6 && v >= 2 * (ds - 3) && v <= 7);
    else
      ddraw = !nat && ds <= 5;
    seq = {6'h00, 6'h01, 6'h08, 6'h02, 6'h10, 6'h00};
    if (pdraw) begin seq.push_back(6'h04); seq.push_back(6'h00); end
    if (ddraw) seq.push_back(6'h20);
    seq.push_back(6'h00);
    fp = pdraw ? psf : ps;
    fd = ddraw ? dsf : ds;
    lights = {fp >= fd, fd >= fp};
    for (int i = 0; i < NS; i++)
      exp_tr[i] = (i < seq.size()) ? {2'b00, seq[i]} : {lights, 6'h00};
  endtask

  // Deal one hand from reset; the datapath stand-in updates a score after its
  // third-card load, so EVAL_P/EVAL_D see two-card scores and SCORE sees final.
  task automatic run_hand(input logic [3:0] ps, input logic [3:0] ds,
                          input logic [3:0] pc, input logic [3:0] psf,
                          input logic [3:0] dsf);
    @(negedge slow_clock);
    resetb = 1'b0;
    pscore = ps; dscore = ds; pcard3 = pc;
    @(negedge slow_clock);
    resetb = 1'b1;
    for (int i = 0; i < NS; i++) begin
      obs_tr[i] = outs();
      if (load_pcard3) pscore = psf;
      if (load_dcard3) dscore = dsf;
      @(negedge slow_clock);
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    #3;
    n_cmp++;
    if (outs() !== 8'h00) begin
      n_err++; $display("FAIL reset_outputs got=%h want=00", outs());
    end
    @(negedge slow_clock);
    resetb = 1'b1;
    #1;
    n_cmp++;
    if (outs() !== 8'h00) begin
      n_err++; $display("FAIL rst_state_no_load got=%h want=00", outs());
    end
    @(negedge slow_clock);
    n_cmp++;
    if (outs() !== 8'h01) begin
      n_err++; $display("FAIL first_edge_p1 got=%h want=01", outs());
    end
  endtask

  task automatic test_directed();
    // ps, ds, pcard3, final ps, final ds, expected lights {p,d}
    int tbl [7][6] = '{
      '{9, 3,  5, 9, 3, 2},
      '{6, 4,  1, 6, 7, 1},
      '{3, 3,  8, 1, 3, 1},
      '{2, 3, 12, 5, 5, 3},
      '{4, 7,  5, 9, 7, 2},
      '{4, 3, 15, 4, 9, 1},
      '{3, 12, 2, 3, 3, 1}
    };
    for (int c = 0; c < 7; c++) begin
      run_hand(tbl[c][0][3:0], tbl[c][1][3:0], tbl[c][2][3:0],
               tbl[c][3][3:0], tbl[c][4][3:0]);
      model_hand(tbl[c][0], tbl[c][1], tbl[c][2], tbl[c][3], tbl[c][4]);
      for (int i = 0; i < NS; i++) begin
        n_cmp++;
        if (obs_tr[i] !== exp_tr[i]) begin
          n_err++;
          $display("FAIL directed case=%0d step=%0d got=%h want=%h",
                   c, i, obs_tr[i], exp_tr[i]);
        end
      end
      n_cmp++;
      if (obs_tr[NS-1][7:6] !== tbl[c][5][1:0]) begin
        n_err++;
        $display("FAIL directed_lights case=%0d got=%b want=%b",
                 c, obs_tr[NS-1][7:6], tbl[c][5][1:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] ps, ds, pc, psf, dsf;
    for (int h = 0; h < 60; h++) begin
      ps  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                         : 4'($urandom_range(0, 9));
      ds  = 4'($urandom_range(0, 9));
      pc  = 4'($urandom_range(0, 15));
      psf = 4'($urandom_range(0, 9));
      dsf = 4'($urandom_range(0, 9));
      run_hand(ps, ds, pc, psf, dsf);
      model_hand(ps, ds, pc, psf, dsf);
      for (int i = 0; i < NS; i++) begin
        n_cmp++;
        if (obs_tr[i] !== exp_tr[i]) begin
          n_err++;
          $display("FAIL random hand=%0d ps=%0d ds=%0d pc=%0d step=%0d got=%h want=%h",
                   h, ps, ds, pc, i, obs_tr[i], exp_tr[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_deal();
    @(negedge slow_clock);
    resetb = 1'b0;
    pscore = 4'd3; dscore = 4'd7; pcard3 = 4'd5;
    @(negedge slow_clock);
    resetb = 1'b1;
    repeat (6) @(negedge slow_clock);
    n_cmp++;
    if (outs() !== 8'h04) begin
      n_err++; $display("FAIL mid_deal_in_p3 got=%h want=04", outs());
    end
    #2 resetb = 1'b0;
    #1;
    n_cmp++;
    if (outs() !== 8'h00) begin
      n_err++; $display("FAIL async_reset_p3 got=%h want=00", outs());
    end
    // Reach DONE with both lights lit, then reset between edges.
    @(negedge slow_clock);
    pscore = 4'd9; dscore = 4'd9;
    resetb = 1'b1;
    repeat (8) @(negedge slow_clock);
    n_cmp++;
    if (outs() !== 8'hC0) begin
      n_err++; $display("FAIL done_tie_lights got=%h want=c0", outs());
    end
    #2 resetb = 1'b0;
    #1;
    n_cmp++;
    if (outs() !== 8'h00) begin
      n_err++; $display("FAIL async_reset_done got=%h want=00", outs());
    end
    @(negedge slow_clock);
    resetb = 1'b1;
    @(negedge slow_clock);
    n_cmp++;
    if (outs() !== 8'h01) begin
      n_err++; $display("FAIL restart_p1 got=%h want=01", outs());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_deal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
